// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA output stage.
// Pixel and line counters plus sync, blank and strobe decodes, all registered.
// Outputs are decoded from the next-state counter values, so every output lines up
// with the pixel_count/line_count presented in the same cycle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             pixel_ce,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] line_count,
  output logic             h_synch,
  output logic             v_synch,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Decode boundaries at counter width; sync end is exclusive.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_pixel_count;
  logic [CNT_W-1:0] r_line_count;
  logic             r_h_synch;
  logic             r_v_synch;
  logic             r_blank;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_pix_last;
  logic             w_line_last;
  logic [CNT_W-1:0] w_pix_next;
  logic [CNT_W-1:0] w_line_next;
  logic             w_h_synch_next;
  logic             w_v_synch_next;
  logic             w_blank_next;
  logic             w_line_start_next;
  logic             w_frame_start_next;

  // Next-state counters: pixel wraps at end of line, line wraps at end of frame.
  always_comb begin
    w_pix_last  = (r_pixel_count == H_LAST);
    w_line_last = (r_line_count == V_LAST);
    w_pix_next  = w_pix_last ? '0 : r_pixel_count + 1'b1;
    w_line_next = r_line_count;
    if (w_pix_last) begin
      w_line_next = w_line_last ? '0 : r_line_count + 1'b1;
    end
  end

  // Decode outputs from the next-state counters so they register alongside them.
  always_comb begin
    w_blank_next       = (w_pix_next >= H_ACT_END) || (w_line_next >= V_ACT_END);
    w_h_synch_next     = ((w_pix_next >= H_SYNC_BEG) && (w_pix_next < H_SYNC_END)) ?
                         SYNC_POL : ~SYNC_POL;
    // Vertical sync spans whole lines, so its edges land on pixel 0.
    w_v_synch_next     = ((w_line_next >= V_SYNC_BEG) && (w_line_next < V_SYNC_END)) ?
                         SYNC_POL : ~SYNC_POL;
    w_line_start_next  = (w_pix_next == '0);
    w_frame_start_next = (w_pix_next == '0) && (w_line_next == '0);
  end

  // State registers; reset parks on the last back-porch pixel of the frame.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_pixel_count <= H_LAST;
      r_line_count  <= V_LAST;
      r_blank       <= 1'b1;
      r_h_synch     <= ~SYNC_POL;
      r_v_synch     <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pixel_ce) begin
      r_pixel_count <= w_pix_next;
      r_line_count  <= w_line_next;
      r_blank       <= w_blank_next;
      r_h_synch     <= w_h_synch_next;
      r_v_synch     <= w_v_synch_next;
      r_line_start  <= w_line_start_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign pixel_count = r_pixel_count;
  assign line_count  = r_line_count;
  assign h_synch     = r_h_synch;
  assign v_synch     = r_v_synch;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations share clock, reset and enable.
// Stimulus pushes expected output bundles; a monitor pops and compares after each edge.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b0;
  logic sample_req = 1'b0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  logic [10:0] pc_a, lc_a, pc_b, lc_b, pc_c, lc_c;
  logic hs_a, vs_a, bl_a, ls_a, fs_a;
  logic hs_b, vs_b, bl_b, ls_b, fs_b;
  logic hs_c, vs_c, bl_c, ls_c, fs_c;

  // A: defaults. B: short lines, default vertical. C: tiny, active-high syncs.
  vga_timing_gen u_dut_a (
    .pixel_clock(clk), .reset(rst), .pixel_ce(ce),
    .pixel_count(pc_a), .line_count(lc_a), .h_synch(hs_a), .v_synch(vs_a),
    .blank(bl_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)
  ) u_dut_b (
    .pixel_clock(clk), .reset(rst), .pixel_ce(ce),
    .pixel_count(pc_b), .line_count(lc_b), .h_synch(hs_b), .v_synch(vs_b),
    .blank(bl_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
  ) u_dut_c (
    .pixel_clock(clk), .reset(rst), .pixel_ce(ce),
    .pixel_count(pc_c), .line_count(lc_c), .h_synch(hs_c), .v_synch(vs_c),
    .blank(bl_c), .line_start(ls_c), .frame_start(fs_c)
  );

  // Bundle layout: {p[10:0], l[10:0], hs, vs, blank, line_start, frame_start}
  logic [26:0] got_a, got_b, got_c;
  assign got_a = {pc_a, lc_a, hs_a, vs_a, bl_a, ls_a, fs_a};
  assign got_b = {pc_b, lc_b, hs_b, vs_b, bl_b, ls_b, fs_b};
  assign got_c = {pc_c, lc_c, hs_c, vs_c, bl_c, ls_c, fs_c};

  typedef struct {
    int          dut;
    string       name;
    logic [26:0] exp;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;  // enabled edges since reset, as seen after the next edge

  // Reference: position from enabled-edge count, then decode with hand boundaries.
  function automatic logic [26:0] model(input int ha, input int hf, input int hsw, input int hb,
                                        input int va, input int vf, input int vsw, input int vb,
                                        input bit pol, input int cnt);
    int ht, vt, idx, p, l;
    logic hs, vs, bl, ls, fs;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (cnt == 0) begin
      p = ht - 1;
      l = vt - 1;
    end else begin
      idx = (cnt - 1) % (ht * vt);
      p = idx % ht;
      l = idx / ht;
    end
    bl = (p >= ha) || (l >= va);
    hs = ((p >= ha + hf) && (p < ha + hf + hsw)) ? pol : !pol;
    vs = ((l >= va + vf) && (l < va + vf + vsw)) ? pol : !pol;
    ls = (p == 0);
    fs = (p == 0) && (l == 0);
    return {11'(p), 11'(l), hs, vs, bl, ls, fs};
  endfunction

  task automatic push(input int d, input string nm, input logic [26:0] e);
    chk_t c;
    c.dut = d;
    c.name = nm;
    c.exp = e;
    q.push_back(c);
  endtask

  // Expected bundles for the state after the next edge, plus hand-computed spot checks.
  task automatic push_all();
    push(0, "model_a", model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n));
    push(1, "model_b", model(16, 1, 2, 1, 480, 10, 2, 33, 1'b0, n));
    push(2, "model_c", model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, n));
    case (n)
      0: begin
        push(0, "reset_a", {11'd799, 11'd524, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        push(1, "reset_b", {11'd19, 11'd524, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        push(2, "reset_c", {11'd7, 11'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
      1: begin
        push(0, "first_edge_a", {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        push(2, "first_edge_c", {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      end
      6:    push(2, "small_hs_on", {11'd5, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      8:    push(2, "small_hs_off", {11'd7, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      33:   push(2, "small_vs_on", {11'd0, 11'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
      48:   push(2, "small_last", {11'd7, 11'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      49:   push(2, "small_wrap", {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      97:   push(2, "small_wrap2", {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      640:  push(0, "last_active", {11'd639, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      641:  push(0, "blank_rise", {11'd640, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      656:  push(0, "pre_hsync", {11'd655, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      657:  push(0, "hsync_fall", {11'd656, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      752:  push(0, "hsync_last", {11'd751, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      753:  push(0, "hsync_rise", {11'd752, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      801:  push(0, "line1_start", {11'd0, 11'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
      1601: push(0, "line2_start", {11'd0, 11'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
      9601: push(1, "vblank_start", {11'd0, 11'd480, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
      9800: push(1, "pre_vsync", {11'd19, 11'd489, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      9801: push(1, "vsync_fall", {11'd0, 11'd490, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      9840: push(1, "vsync_last", {11'd19, 11'd491, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      9841: push(1, "vsync_rise", {11'd0, 11'd492, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
      10500: push(1, "frame_last", {11'd19, 11'd524, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      10501: push(1, "frame_wrap", {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
      default: ;
    endcase
  endtask

  // One clock: drive inputs mid-cycle and queue what the next edge must produce.
  task automatic cycle(input bit ce_v, input bit rst_v);
    @(negedge clk);
    ce = ce_v;
    rst = rst_v;
    if (rst_v) n = 0;
    else if (ce_v) n = n + 1;
    push_all();
  endtask

  // Request an immediate off-edge comparison of whatever is queued.
  task automatic sample_now();
    #1 sample_req = 1'b1;
    #1 sample_req = 1'b0;
    #3;
  endtask

  // Monitor: after each edge (or an off-edge request) compare every queued entry.
  initial begin
    chk_t c;
    logic [26:0] g;
    forever begin
      @(posedge clk or posedge sample_req);
      #2;
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.dut)
          0:       g = got_a;
          1:       g = got_b;
          default: g = got_c;
        endcase
        checks++;
        if (g !== c.exp) begin
          errors++;
          $display("FAIL %s dut%0d: got p=%0d l=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, expected p=%0d l=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                   c.name, c.dut, g[26:16], g[15:5], g[4], g[3], g[2], g[1], g[0],
                   c.exp[26:16], c.exp[15:5], c.exp[4], c.exp[3], c.exp[2], c.exp[1],
                   c.exp[0]);
        end
      end
    end
  end

  initial begin
    // Reset with the clock stopped: outputs must settle asynchronously.
    #1 rst = 1'b1;
    #2;
    n = 0;
    push_all();
    sample_now();

    clk_run = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);

    // Free-running: covers a full frame of B and the first lines of A.
    for (int i = 0; i < 10600; i++) cycle(1'b1, 1'b0);

    // Alternate enables: outputs hold across disabled cycles, strobes last 2 clocks.
    for (int i = 0; i < 21100; i++) cycle(i[0] == 1'b0, 1'b0);

    // Run to B at (p=10, l=300), then reset between edges.
    while (((n - 1) % 10500) != 6010) cycle(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    push_all();
    sample_now();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 120; i++) cycle(1'b1, 1'b0);

    cycle(1'b0, 1'b0);
    @(posedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
